sw_cfg_table: RTL and testbench

Parametrised configuration table for the packet router's output-port address map, driven by the switch memory-configuration port (`mem_en`/`mem_wr`/`mem_addr`/`mem_data`). It holds a shadow copy, written by software/testbench, and an active copy, used by the router's address lookup. A commit request transfers shadow to active atomically, only while the router reports idle, so the lookup never sees a half-updated map. Readback is registered with a valid strobe, and unmapped accesses are flagged.

---
 rtl/sw_cfg_table.sv | 138 +++++++++++++
 tb/tb_sw_cfg_table.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_cfg_table.sv
// sw_cfg_table: output-port address map for the packet router.
//   Software writes a shadow copy through the memory-config port. A commit
//   copies shadow to active in one edge, and only while the router is idle,
//   so the lookup never sees a half-updated map.
// Optional feature macro: SW_CFG_PARITY_EN. When defined, each active entry
//   carries an even-parity bit, and a sticky parity_err is raised.
// Ports:
//   clk, rst (async, active-low)
//   mem_en/mem_wr/mem_addr/mem_data : config access
//   mem_rdata/mem_rvalid            : registered read return, 1-cycle latency
//   router_idle                     : commit gate
//   port_addr                       : active table, entry i at [i*DATA_W +: DATA_W]
//   cfg_pending/cfg_commit/cfg_err/parity_err : status
// Address map: 0..NUM_PORTS-1 entries, NUM_PORTS CTRL, NUM_PORTS+1 STATUS.
module sw_cfg_table #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_en,
  input  logic                        mem_wr,
  input  logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data,
  output logic [DATA_W-1:0]           mem_rdata,
  output logic                        mem_rvalid,
  input  logic                        router_idle,
  output logic [NUM_PORTS*DATA_W-1:0] port_addr,
  output logic                        cfg_pending,
  output logic                        cfg_commit,
  output logic                        cfg_err,
  output logic                        parity_err
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_PORTS);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0][DATA_W-1:0] r_shadow, r_active;
  logic [NUM_PORTS-1:0]             r_dirty;
  logic                             r_pending, r_commit, r_err, r_rvalid;
  logic [DATA_W-1:0]                r_rdata;

  logic w_wr, w_rd, w_is_entry, w_is_ctrl, w_is_stat, w_unmapped_acc;
  logic w_ctrl_wr, w_commit_req, w_discard, w_err_clr, w_do_commit;
  logic [DATA_W-1:0] w_rd_mux;

  assign w_wr           = mem_en & mem_wr;
  assign w_rd           = mem_en & ~mem_wr;
  assign w_is_entry     = (mem_addr < A_CTRL);
  assign w_is_ctrl      = (mem_addr == A_CTRL);
  assign w_is_stat      = (mem_addr == A_STAT);
  assign w_unmapped_acc = mem_en & ~(w_is_entry | w_is_ctrl | w_is_stat);

  assign w_ctrl_wr    = w_wr & w_is_ctrl;
  assign w_commit_req = w_ctrl_wr & mem_data[0];
  // Commit wins over discard when both bits are written together.
  assign w_discard    = w_ctrl_wr & mem_data[1] & ~mem_data[0];
  assign w_err_clr    = w_ctrl_wr & mem_data[2];
  // Pending is registered, so a CTRL commit lands one edge after the write.
  assign w_do_commit  = r_pending & router_idle;

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (mem_addr == ADDR_W'(i)) w_rd_mux = r_shadow[i];
    if (w_is_stat) w_rd_mux[3:0] = {parity_err, r_err, |r_dirty, r_pending};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_dirty   <= '0;
      r_pending <= 1'b0;
      r_commit  <= 1'b0;
      r_err     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_commit  <= w_do_commit;
      // A request seen while already pending (even on the commit edge) adds nothing.
      r_pending <= w_do_commit ? 1'b0 : (r_pending | w_commit_req);
      if (w_do_commit) begin
        r_active <= r_shadow;
        r_dirty  <= '0;
      end
      if (w_discard) begin
        r_shadow <= r_active;
        r_dirty  <= '0;
      end
      // Entry write after commit/discard: new data stays in shadow and is marked dirty.
      for (int i = 0; i < NUM_PORTS; i++)
        if (w_wr && w_is_entry && mem_addr == ADDR_W'(i)) begin
          r_shadow[i] <= mem_data;
          r_dirty[i]  <= 1'b1;
        end
      if (w_err_clr)      r_err <= 1'b0;
      if (w_unmapped_acc) r_err <= 1'b1;
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rd_mux;
    end
  end

`ifdef SW_CFG_PARITY_EN
  logic [NUM_PORTS-1:0] r_par, w_par_bad;
  logic                 r_parity_err;

  always_comb begin
    w_par_bad = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_par_bad[i] = (^r_active[i]) ^ r_par[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par        <= '0;
      r_parity_err <= 1'b0;
    end else if (w_do_commit) begin
      for (int i = 0; i < NUM_PORTS; i++) r_par[i] <= ^r_shadow[i];
      r_parity_err <= 1'b0;
    end else if (|w_par_bad) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign mem_rdata   = r_rdata;
  assign mem_rvalid  = r_rvalid;
  assign port_addr   = r_active;
  assign cfg_pending = r_pending;
  assign cfg_commit  = r_commit;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_sw_cfg_table.sv
// Bench for sw_cfg_table: directed vector table, reset corner, then random
// traffic checked against an array-based reference model.
module tb_sw_cfg_table;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wr, router_idle;
  logic [2:0]  mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic [31:0] port_addr;
  logic        cfg_pending, cfg_commit, cfg_err, parity_err;

  int total = 0;
  int bad   = 0;

  sw_cfg_table #(.NUM_PORTS(4), .DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .router_idle(router_idle), .port_addr(port_addr),
    .cfg_pending(cfg_pending), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en, wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic       idle;
    logic       rv;
    logic [7:0] rd;
    logic [31:0] pa;
    logic       pend, com, err;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic en, wr, input logic [2:0] a, input logic [7:0] d,
                     input logic idle, input logic rv, input logic [7:0] rd,
                     input logic [31:0] pa, input logic pend, com, err);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.data = d; v.idle = idle;
    v.rv = rv; v.rd = rd; v.pa = pa; v.pend = pend; v.com = com; v.err = err;
    vq.push_back(v);
  endtask

  task automatic drive(input logic en, wr, input logic [2:0] a, input logic [7:0] d, input logic idle);
    mem_en = en; mem_wr = wr; mem_addr = a; mem_data = d; router_idle = idle;
  endtask

  // Reference model: plain arrays updated from the access rules.
  logic [7:0] m_sh[4], m_ac[4];
  logic [3:0] m_dirty;
  logic       m_pend, m_com, m_err, m_rv;
  logic [7:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_sh[i] = 8'h00; m_ac[i] = 8'h00; end
    m_dirty = 4'h0; m_pend = 1'b0; m_com = 1'b0; m_err = 1'b0; m_rv = 1'b0; m_rd = 8'h00;
  endtask

  task automatic model_step(input logic en, wr, input logic [2:0] a, input logic [7:0] d, input logic idle);
    logic [7:0] o_sh[4];
    logic [7:0] o_ac[4];
    logic       do_c;
    logic [7:0] st;
    o_sh = m_sh;
    o_ac = m_ac;
    do_c = m_pend && idle;
    st   = {4'b0000, 1'b0, m_err, (m_dirty != 4'h0), m_pend};
    if (en && !wr) begin
      m_rv = 1'b1;
      if (a < 3'd4)       m_rd = o_sh[a[1:0]];
      else if (a == 3'd5) m_rd = st;
      else                m_rd = 8'h00;
    end else m_rv = 1'b0;
    m_com = do_c;
    if (do_c) begin m_ac = o_sh; m_dirty = 4'h0; m_pend = 1'b0; end
    if (en && wr) begin
      if (a < 3'd4) begin
        m_sh[a[1:0]] = d; m_dirty[a[1:0]] = 1'b1;
      end else if (a == 3'd4) begin
        if (d[0] && !do_c) m_pend = 1'b1;
        if (d[1] && !d[0]) begin m_sh = o_ac; m_dirty = 4'h0; end
        if (d[2]) m_err = 1'b0;
      end
    end
    if (en && a > 3'd5) m_err = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 3'd0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_port_addr", port_addr, 32'h0);
    chk("rst_rvalid", {31'b0, mem_rvalid}, 32'h0);
    chk("rst_rdata", {24'b0, mem_rdata}, 32'h0);
    chk("rst_pending", {31'b0, cfg_pending}, 32'h0);
    chk("rst_commit", {31'b0, cfg_commit}, 32'h0);
    chk("rst_err", {31'b0, cfg_err}, 32'h0);
    chk("rst_parity", {31'b0, parity_err}, 32'h0);
    rst = 1'b1;

    //   en wr addr data idle | rv rd pa pend com err
    add(1,0,0,8'h00,0, 1,8'h00,32'h0,0,0,0);
    add(1,0,1,8'h00,0, 1,8'h00,32'h0,0,0,0);
    add(1,0,2,8'h00,0, 1,8'h00,32'h0,0,0,0);
    add(1,0,3,8'h00,0, 1,8'h00,32'h0,0,0,0);
    add(1,0,4,8'h00,0, 1,8'h00,32'h0,0,0,0);
    add(1,0,5,8'h00,0, 1,8'h00,32'h0,0,0,0);
    add(1,1,0,8'h11,0, 0,8'h00,32'h0,0,0,0);
    add(1,1,1,8'h22,0, 0,8'h00,32'h0,0,0,0);
    add(1,1,2,8'h33,0, 0,8'h00,32'h0,0,0,0);
    add(1,1,3,8'h44,0, 0,8'h00,32'h0,0,0,0);
    add(1,0,5,8'h00,0, 1,8'h02,32'h0,0,0,0);
    add(1,1,4,8'h01,0, 0,8'h02,32'h0,1,0,0);
    add(1,0,5,8'h00,0, 1,8'h03,32'h0,1,0,0);
    add(0,0,0,8'h00,1, 0,8'h03,32'h44332211,0,1,0);
    add(0,0,0,8'h00,1, 0,8'h03,32'h44332211,0,0,0);
    add(1,1,4,8'h01,0, 0,8'h03,32'h44332211,1,0,0);
    add(1,1,2,8'h55,1, 0,8'h03,32'h44332211,0,1,0);
    add(1,0,2,8'h00,0, 1,8'h55,32'h44332211,0,0,0);
    add(1,0,5,8'h00,0, 1,8'h02,32'h44332211,0,0,0);
    add(1,1,1,8'hAA,0, 0,8'h02,32'h44332211,0,0,0);
    add(1,1,4,8'h02,0, 0,8'h02,32'h44332211,0,0,0);
    add(1,0,1,8'h00,0, 1,8'h22,32'h44332211,0,0,0);
    add(1,0,2,8'h00,0, 1,8'h33,32'h44332211,0,0,0);
    add(1,0,5,8'h00,0, 1,8'h00,32'h44332211,0,0,0);
    add(1,0,7,8'h00,0, 1,8'h00,32'h44332211,0,0,1);
    add(1,0,5,8'h00,0, 1,8'h04,32'h44332211,0,0,1);
    add(1,1,6,8'hFF,0, 0,8'h04,32'h44332211,0,0,1);
    add(1,1,4,8'h04,0, 0,8'h04,32'h44332211,0,0,0);
    add(1,0,6,8'h00,0, 1,8'h00,32'h44332211,0,0,1);
    add(1,1,0,8'h99,1, 0,8'h00,32'h44332211,0,0,1);
    add(1,1,4,8'h07,1, 0,8'h00,32'h44332211,1,0,0);
    add(0,0,0,8'h00,1, 0,8'h00,32'h44332299,0,1,0);
    add(0,0,0,8'h00,1, 0,8'h00,32'h44332299,0,0,0);

    foreach (vq[k]) begin
      drive(vq[k].en, vq[k].wr, vq[k].addr, vq[k].data, vq[k].idle);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rvalid", k), {31'b0, mem_rvalid}, {31'b0, vq[k].rv});
      chk($sformatf("v%0d_rdata", k), {24'b0, mem_rdata}, {24'b0, vq[k].rd});
      chk($sformatf("v%0d_port_addr", k), port_addr, vq[k].pa);
      chk($sformatf("v%0d_pending", k), {31'b0, cfg_pending}, {31'b0, vq[k].pend});
      chk($sformatf("v%0d_commit", k), {31'b0, cfg_commit}, {31'b0, vq[k].com});
      chk($sformatf("v%0d_err", k), {31'b0, cfg_err}, {31'b0, vq[k].err});
      chk($sformatf("v%0d_parity", k), {31'b0, parity_err}, 32'h0);
    end

    // Reset asserted while a commit is pending discards it.
    drive(1, 1, 3'd4, 8'h01, 0);
    @(posedge clk); #1;
    chk("midrst_pend_set", {31'b0, cfg_pending}, 32'h1);
    drive(0, 0, 3'd0, 8'h00, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_pend_clr", {31'b0, cfg_pending}, 32'h0);
    chk("midrst_port_addr", port_addr, 32'h0);
    #1 rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_commit", {31'b0, cfg_commit}, 32'h0);
      chk("midrst_pa_stays", port_addr, 32'h0);
    end

    // Random traffic against the model; DUT is fresh from reset.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic       en, wr, idle;
      logic [2:0] a;
      logic [7:0] d;
      en   = ($urandom_range(0, 3) != 0);
      wr   = $urandom_range(0, 1) == 1;
      a    = 3'($urandom_range(0, 7));
      d    = 8'($urandom);
      idle = ($urandom_range(0, 2) != 0);
      drive(en, wr, a, d, idle);
      model_step(en, wr, a, d, idle);
      @(posedge clk); #1;
      chk("rnd_port_addr", port_addr, {m_ac[3], m_ac[2], m_ac[1], m_ac[0]});
      chk("rnd_pending", {31'b0, cfg_pending}, {31'b0, m_pend});
      chk("rnd_commit", {31'b0, cfg_commit}, {31'b0, m_com});
      chk("rnd_err", {31'b0, cfg_err}, {31'b0, m_err});
      chk("rnd_rvalid", {31'b0, mem_rvalid}, {31'b0, m_rv});
      chk("rnd_rdata", {24'b0, mem_rdata}, {24'b0, m_rd});
      chk("rnd_parity", {31'b0, parity_err}, 32'h0);
    end

`ifdef SW_CFG_PARITY_EN
    begin
      logic [31:0] fv;
      drive(0, 0, 3'd0, 8'h00, 0);
      fv = dut.r_active;
      fv[0] = ~fv[0];
      force dut.r_active = fv;
      @(posedge clk); #1;
      chk("parity_set", {31'b0, parity_err}, 32'h1);
      release dut.r_active;
      drive(1, 1, 3'd4, 8'h01, 1);
      @(posedge clk); #1;
      chk("parity_sticky", {31'b0, parity_err}, 32'h1);
      drive(0, 0, 3'd0, 8'h00, 1);
      @(posedge clk); #1;
      chk("parity_clr_commit", {31'b0, parity_err}, 32'h0);
      @(posedge clk); #1;
      chk("parity_stays_clr", {31'b0, parity_err}, 32'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
